// File: rtl/csr_unit.sv
// Machine-mode CSR access sequencer: one-cycle CSR read-modify-writes plus the
// multi-cycle trap-entry and MRET sequences over a single-port CSR file.
module csr_unit #(
  parameter logic [31:0] CAUSE_ILLEGAL = 32'd2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [11:0] req_addr,
  input  logic [31:0] req_operand,
  input  logic        req_rs1_zero,
  input  logic [31:0] req_pc,
  input  logic [31:0] req_cause,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_redirect,
  output logic        rsp_illegal,
  output logic [31:0] rsp_cause,
  output logic        csr_write_en,
  output logic [11:0] csr_addr,
  output logic [31:0] csr_in,
  input  logic [31:0] csr_out,
  input  logic [31:0] mstatus
);

  typedef enum logic [2:0] {
    IDLE, EXEC, T_EPC, T_CAUSE, T_STAT, T_VEC, M_STAT, M_EPC
  } state_e;

  localparam logic [2:0]  OP_CSRRW = 3'd0;
  localparam logic [2:0]  OP_CSRRS = 3'd1;
  localparam logic [2:0]  OP_CSRRC = 3'd2;
  localparam logic [2:0]  OP_TRAP  = 3'd3;
  localparam logic [2:0]  OP_MRET  = 3'd4;

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MHARTID  = 12'hF14;

  localparam logic [31:0] MIE_BIT  = 32'h0000_0008;
  localparam logic [31:0] MPIE_BIT = 32'h0000_0080;
  localparam logic [31:0] MPP_BITS = 32'h0000_1800;

  state_e      state_q, state_d;
  logic [2:0]  op_q;
  logic [11:0] addr_q;
  logic [31:0] operand_q;
  logic        rs1_zero_q;
  logic [31:0] pc_q;
  logic [31:0] cause_q;

  logic        accept;
  logic        mapped;
  logic        read_only;
  logic        csr_op;
  logic        write_occurs;
  logic        illegal;
  logic [31:0] new_val;

  assign req_ready = (state_q == IDLE) & rst_n;
  assign accept    = req_valid & req_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: the request payload is deliberately not reset; it is only consumed
  // after an acceptance has loaded it, so a reset term would be dead logic.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q       <= req_op;
      addr_q     <= req_addr;
      operand_q  <= req_operand;
      rs1_zero_q <= req_rs1_zero;
      pc_q       <= req_pc;
      cause_q    <= req_cause;
    end
  end

  always_comb begin
    case (addr_q)
      A_MSTATUS, A_MIE, A_MTVEC, A_MSCRATCH,
      A_MEPC, A_MCAUSE, A_MHARTID: mapped = 1'b1;
      default:                     mapped = 1'b0;
    endcase
    read_only    = (addr_q[11:10] == 2'b11);
    csr_op       = (op_q == OP_CSRRW) | (op_q == OP_CSRRS) | (op_q == OP_CSRRC);
    write_occurs = (op_q == OP_CSRRW) | ~rs1_zero_q;
    illegal      = ~mapped | ~csr_op | (write_occurs & read_only);
    case (op_q)
      OP_CSRRW: new_val = operand_q;
      OP_CSRRS: new_val = csr_out | operand_q;
      OP_CSRRC: new_val = csr_out & ~operand_q;
      default:  new_val = 32'h0;
    endcase
  end

  // NOTE: every output and the next state get a default first so no path
  // through the case can leave a value unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    rsp_valid    = 1'b0;
    rsp_data     = 32'h0;
    rsp_redirect = 1'b0;
    rsp_illegal  = 1'b0;
    rsp_cause    = 32'h0;
    csr_write_en = 1'b0;
    csr_addr     = 12'h0;
    csr_in       = 32'h0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          case (req_op)
            OP_TRAP: state_d = T_EPC;
            OP_MRET: state_d = M_STAT;
            default: state_d = EXEC;
          endcase
        end
      end
      EXEC: begin
        csr_addr     = addr_q;
        csr_in       = new_val;
        csr_write_en = write_occurs & ~illegal;
        rsp_valid    = 1'b1;
        rsp_data     = illegal ? 32'h0 : csr_out;
        rsp_illegal  = illegal;
        rsp_cause    = illegal ? CAUSE_ILLEGAL : 32'h0;
        state_d      = IDLE;
      end
      T_EPC: begin
        csr_addr     = A_MEPC;
        csr_in       = pc_q & ~32'h3;
        csr_write_en = 1'b1;
        state_d      = T_CAUSE;
      end
      T_CAUSE: begin
        csr_addr     = A_MCAUSE;
        csr_in       = cause_q;
        csr_write_en = 1'b1;
        state_d      = T_STAT;
      end
      T_STAT: begin
        // Stash MIE into MPIE, disable interrupts, record M-mode as previous.
        csr_addr     = A_MSTATUS;
        csr_in       = (mstatus & ~(MIE_BIT | MPIE_BIT | MPP_BITS))
                     | (mstatus[3] ? MPIE_BIT : 32'h0) | MPP_BITS;
        csr_write_en = 1'b1;
        state_d      = T_VEC;
      end
      T_VEC: begin
        csr_addr     = A_MTVEC;
        rsp_valid    = 1'b1;
        rsp_redirect = 1'b1;
        rsp_data     = csr_out & ~32'h3;
        state_d      = IDLE;
      end
      M_STAT: begin
        csr_addr     = A_MSTATUS;
        csr_in       = (mstatus & ~(MIE_BIT | MPIE_BIT | MPP_BITS))
                     | (mstatus[7] ? MIE_BIT : 32'h0) | MPIE_BIT | MPP_BITS;
        csr_write_en = 1'b1;
        state_d      = M_EPC;
      end
      M_EPC: begin
        csr_addr     = A_MEPC;
        rsp_valid    = 1'b1;
        rsp_redirect = 1'b1;
        rsp_data     = csr_out;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_csr_unit.sv
// Self-checking bench for csr_unit: a behavioural CSR file on the DUT's CSR
// port, directed scenarios, and randomized requests against a reference model.
module tb_csr_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = '0;
  logic [11:0] req_addr = '0;
  logic [31:0] req_operand = '0;
  logic        req_rs1_zero = 1'b0;
  logic [31:0] req_pc = '0;
  logic [31:0] req_cause = '0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_redirect;
  logic        rsp_illegal;
  logic [31:0] rsp_cause;
  logic        csr_write_en;
  logic [11:0] csr_addr;
  logic [31:0] csr_in;
  logic [31:0] csr_out;
  logic [31:0] mstatus;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] last_data;

  localparam logic [11:0] MAPS [7] = '{12'h300, 12'h304, 12'h305, 12'h340,
                                       12'h341, 12'h342, 12'hF14};

  // CSR file seen by the DUT; pokes let the bench preload any register.
  logic [31:0] f_mem [7];
  logic        poke_en = 1'b0;
  int          poke_idx = 0;
  logic [31:0] poke_val = '0;

  // Reference model: CSR contents keyed by architectural address.
  logic [31:0] m [logic [11:0]];

  function automatic int idx_of(input logic [11:0] a);
    for (int i = 0; i < 7; i++) if (MAPS[i] == a) return i;
    return -1;
  endfunction

  always_comb begin
    csr_out = 32'h0;
    if (idx_of(csr_addr) >= 0) csr_out = f_mem[idx_of(csr_addr)];
  end
  assign mstatus = f_mem[0];

  always @(posedge clk) begin
    if (poke_en) f_mem[poke_idx] <= poke_val;
    else if (csr_write_en && idx_of(csr_addr) >= 0) f_mem[idx_of(csr_addr)] <= csr_in;
  end

  always #5 clk = ~clk;

  csr_unit #(.CAUSE_ILLEGAL(32'd2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_operand(req_operand), .req_rs1_zero(req_rs1_zero),
    .req_pc(req_pc), .req_cause(req_cause),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_redirect(rsp_redirect),
    .rsp_illegal(rsp_illegal), .rsp_cause(rsp_cause),
    .csr_write_en(csr_write_en), .csr_addr(csr_addr), .csr_in(csr_in),
    .csr_out(csr_out), .mstatus(mstatus)
  );

  task automatic poke(input logic [11:0] a, input logic [31:0] v);
    @(negedge clk);
    poke_en = 1'b1; poke_idx = idx_of(a); poke_val = v;
    @(posedge clk); #1;
    poke_en = 1'b0;
    m[a] = v;
  endtask

  task automatic model_req(input logic [2:0] op, input logic [11:0] addr,
                           input logic [31:0] opnd, input logic rz,
                           input logic [31:0] pc, input logic [31:0] cause,
                           output logic [31:0] e_data, output logic e_redir,
                           output logic e_ill, output logic [31:0] e_cause,
                           output int e_lat, output int e_wr);
    logic [31:0] ms, old;
    logic wr;
    e_data = 0; e_redir = 0; e_ill = 0; e_cause = 0; e_wr = 0; e_lat = 1;
    if (op == 3'd3) begin
      ms = m[12'h300];
      m[12'h341] = pc & ~32'h3;
      m[12'h342] = cause;
      m[12'h300] = (ms & ~32'h1888) | (ms[3] ? 32'h80 : 32'h0) | 32'h1800;
      e_data = m[12'h305] & ~32'h3; e_redir = 1; e_lat = 4; e_wr = 3;
    end else if (op == 3'd4) begin
      ms = m[12'h300];
      m[12'h300] = (ms & ~32'h1888) | (ms[7] ? 32'h8 : 32'h0) | 32'h1880;
      e_data = m[12'h341]; e_redir = 1; e_lat = 2; e_wr = 1;
    end else begin
      old = m.exists(addr) ? m[addr] : 32'h0;
      wr = (op == 3'd0) || !rz;
      e_ill = !m.exists(addr) || (op > 3'd4) || (wr && addr[11:10] == 2'b11);
      if (e_ill) e_cause = 32'd2;
      else begin
        e_data = old;
        if (wr) begin
          m[addr] = (op == 3'd0) ? opnd : (op == 3'd1) ? (old | opnd) : (old & ~opnd);
          e_wr = 1;
        end
      end
    end
  endtask

  task automatic check_file(input string tag);
    for (int i = 0; i < 7; i++) begin
      n_cmp++;
      if (f_mem[i] !== m[MAPS[i]]) begin
        n_bad++;
        $display("FAIL %s csr[%h]: got %h expected %h", tag, MAPS[i], f_mem[i], m[MAPS[i]]);
      end
    end
  endtask

  task automatic do_req(input logic [2:0] op, input logic [11:0] addr,
                        input logic [31:0] opnd, input logic rz,
                        input logic [31:0] pc, input logic [31:0] cause,
                        input string tag);
    logic [31:0] e_data, e_cause;
    logic e_redir, e_ill;
    int e_lat, e_wr, cyc, writes;
    bit got;
    model_req(op, addr, opnd, rz, pc, cause, e_data, e_redir, e_ill, e_cause, e_lat, e_wr);
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++; $display("FAIL %s ready: got %b expected 1", tag, req_ready);
    end
    req_valid = 1'b1; req_op = op; req_addr = addr; req_operand = opnd;
    req_rs1_zero = rz; req_pc = pc; req_cause = cause;
    @(posedge clk);
    @(negedge clk);
    // Scramble the bus after acceptance: the DUT must work from latched fields.
    req_valid = 1'b0; req_op = 3'($urandom); req_addr = 12'($urandom);
    req_operand = $urandom; req_rs1_zero = 1'($urandom);
    req_pc = $urandom; req_cause = $urandom;
    cyc = 1; writes = 0; got = 0;
    while (!got && cyc <= 8) begin
      if (csr_write_en) writes++;
      if (rsp_valid) begin
        got = 1;
        last_data = rsp_data;
        n_cmp++;
        if (cyc != e_lat || rsp_data !== e_data || rsp_redirect !== e_redir ||
            rsp_illegal !== e_ill || rsp_cause !== e_cause) begin
          n_bad++;
          $display("FAIL %s rsp: got lat=%0d data=%h redir=%b ill=%b cause=%h expected lat=%0d data=%h redir=%b ill=%b cause=%h",
                   tag, cyc, rsp_data, rsp_redirect, rsp_illegal, rsp_cause,
                   e_lat, e_data, e_redir, e_ill, e_cause);
        end
      end else begin
        n_cmp++;
        if ({rsp_data, rsp_redirect, rsp_illegal, rsp_cause} !== '0 || req_ready !== 1'b0) begin
          n_bad++;
          $display("FAIL %s busy cycle %0d: got data=%h redir=%b ill=%b cause=%h ready=%b expected all 0",
                   tag, cyc, rsp_data, rsp_redirect, rsp_illegal, rsp_cause, req_ready);
        end
        @(negedge clk);
        cyc++;
      end
    end
    n_cmp++;
    if (!got) begin
      n_bad++; $display("FAIL %s timeout: got no rsp_valid expected one at cycle %0d", tag, e_lat);
    end
    n_cmp++;
    if (writes != e_wr) begin
      n_bad++; $display("FAIL %s write pulses: got %0d expected %0d", tag, writes, e_wr);
    end
    @(posedge clk); #1;
    check_file(tag);
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if ({req_ready, rsp_valid, rsp_data, rsp_redirect, rsp_illegal, rsp_cause,
         csr_write_en, csr_addr, csr_in} !== '0) begin
      n_bad++; $display("FAIL reset outputs: got nonzero expected all 0");
    end
    for (int i = 0; i < 7; i++) begin
      f_mem[i] = 32'h0;
      m[MAPS[i]] = 32'h0;
    end
    @(negedge clk); rst_n = 1'b1; #1;
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset release ready: got %b expected 1", req_ready);
    end
  endtask

  task automatic test_csrrw();
    poke(12'h340, 32'h11);
    do_req(3'd0, 12'h340, 32'hAA, 1'b0, 0, 0, "csrrw_mscratch");
    n_cmp++;
    if (last_data !== 32'h11 || f_mem[3] !== 32'hAA) begin
      n_bad++; $display("FAIL csrrw_plan: got old=%h new=%h expected 11 aa", last_data, f_mem[3]);
    end
  endtask

  task automatic test_set_clear();
    poke(12'h304, 32'h0F0);
    do_req(3'd1, 12'h304, 32'h808, 1'b0, 0, 0, "csrrs_mie");
    n_cmp++;
    if (last_data !== 32'h0F0 || f_mem[1] !== 32'h8F8) begin
      n_bad++; $display("FAIL csrrs_plan: got old=%h mie=%h expected 0f0 8f8", last_data, f_mem[1]);
    end
    do_req(3'd2, 12'h304, 32'h0F0, 1'b0, 0, 0, "csrrc_mie");
    n_cmp++;
    if (f_mem[1] !== 32'h808) begin
      n_bad++; $display("FAIL csrrc_plan: got mie=%h expected 808", f_mem[1]);
    end
    do_req(3'd1, 12'h304, 32'h0, 1'b1, 0, 0, "csrrs_rs1zero");
    do_req(3'd2, 12'h304, 32'h0, 1'b1, 0, 0, "csrrc_rs1zero");
  endtask

  task automatic test_hartid_illegal();
    poke(12'hF14, 32'h5);
    do_req(3'd1, 12'hF14, 32'h0, 1'b1, 0, 0, "hartid_read");
    n_cmp++;
    if (last_data !== 32'h5) begin
      n_bad++; $display("FAIL hartid_plan: got %h expected 5", last_data);
    end
    do_req(3'd0, 12'hF14, 32'h1234, 1'b0, 0, 0, "hartid_write");
    do_req(3'd1, 12'h7C0, 32'h0, 1'b1, 0, 0, "unmapped_7c0");
    do_req(3'd6, 12'h340, 32'h1, 1'b0, 0, 0, "reserved_op");
  endtask

  task automatic test_trap_mret();
    poke(12'h305, 32'h1003);
    poke(12'h300, 32'h8);
    do_req(3'd3, 12'h0, 32'h0, 1'b0, 32'h2002, 32'd11, "trap");
    n_cmp++;
    if (last_data !== 32'h1000 || f_mem[4] !== 32'h2000 || f_mem[5] !== 32'd11 ||
        f_mem[0] !== 32'h1880) begin
      n_bad++;
      $display("FAIL trap_plan: got vec=%h mepc=%h mcause=%h mstatus=%h expected 1000 2000 b 1880",
               last_data, f_mem[4], f_mem[5], f_mem[0]);
    end
    do_req(3'd4, 12'h0, 32'h0, 1'b0, 0, 0, "mret");
    n_cmp++;
    if (last_data !== 32'h2000 || f_mem[0] !== 32'h1888) begin
      n_bad++; $display("FAIL mret_plan: got pc=%h mstatus=%h expected 2000 1888", last_data, f_mem[0]);
    end
  endtask

  task automatic test_reset_mid_trap();
    bit seen_rsp;
    poke(12'h342, 32'h77);
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd3; req_pc = 32'h4446; req_cause = 32'h99;
    @(posedge clk);             // accepted; T_EPC follows
    @(negedge clk); req_valid = 1'b0;
    @(posedge clk);             // mepc lands; now in T_CAUSE
    #2; rst_n = 1'b0; #1;
    n_cmp++;
    if ({req_ready, rsp_valid, rsp_data, rsp_redirect, rsp_illegal, rsp_cause,
         csr_write_en, csr_addr, csr_in} !== '0) begin
      n_bad++; $display("FAIL midreset outputs: got write_en=%b addr=%h ready=%b expected all 0",
                        csr_write_en, csr_addr, req_ready);
    end
    m[12'h341] = 32'h4444;
    seen_rsp = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (rsp_valid) seen_rsp = 1;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rsp_valid) seen_rsp = 1;
    end
    n_cmp++;
    if (seen_rsp || req_ready !== 1'b1) begin
      n_bad++; $display("FAIL midreset after: got rsp_seen=%b ready=%b expected 0 1", seen_rsp, req_ready);
    end
    check_file("midreset_file");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++)
      do_req(3'd0, 12'h340, $urandom, 1'b0, 0, 0, "back_to_back");
  endtask

  task automatic test_random();
    logic [11:0] addr;
    logic [2:0]  op;
    int          r;
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 9);
      addr = (r < 7) ? MAPS[r] : (r == 7) ? 12'hC00 : 12'($urandom);
      r = $urandom_range(0, 19);
      op = (r < 14) ? 3'(r % 3) : (r < 16) ? 3'd3 : (r < 18) ? 3'd4 : 3'($urandom_range(5, 7));
      do_req(op, addr, $urandom, ($urandom_range(0, 3) == 0), $urandom, $urandom, "random");
    end
  endtask

  initial begin
    test_reset();
    test_csrrw();
    test_set_clear();
    test_hartid_illegal();
    test_trap_mret();
    test_reset_mid_trap();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/csr_unit.md
# csr_unit

Machine-mode CSR access sequencer in the core. It sits between the execute stage and the single-port CSR register file, and drives that file's write enable, address and write-data inputs while reading its combinational data output. It executes CSRRW/CSRRS/CSRRC (register and immediate forms) as one-cycle read-modify-writes. It also runs the multi-cycle trap-entry and MRET sequences, because the file can do only one access per cycle.

## Interface
- `CAUSE_ILLEGAL`, default 32'd2: mcause value reported on `rsp_cause` for an illegal CSR access.
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept a request.
- `req_op`  in  3  operation code: 0 CSRRW, 1 CSRRS, 2 CSRRC, 3 TRAP, 4 MRET, 5-7 reserved.
- `req_addr`  in  12  CSR address (CSR ops only).
- `req_operand`  in  32  rs1 value, or zero-extended zimm.
- `req_rs1_zero`  in  1  rs1/zimm field is zero; suppresses the write for CSRRS/CSRRC.
- `req_pc`  in  32  faulting PC (TRAP only).
- `req_cause`  in  32  mcause value (TRAP only).
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_data`  out  32  result; meaning depends on the operation (see Operation).
- `rsp_redirect`  out  1  `rsp_data` is a fetch target.
- `rsp_illegal`  out  1  access was illegal; no CSR was modified.
- `csr_write_en`  out  1  write strobe to the CSR file.
- `csr_addr`  out  12  CSR file address.
- `csr_in`  out  32  CSR file write data.
- `csr_out`  in  32  CSR file read data (combinational).
- `mstatus`  in  32  mstatus value from the CSR file.

## Operation
- Mapped CSRs: 0x300 mstatus, 0x304 mie, 0x305 mtvec, 0x340 mscratch, 0x341 mepc, 0x342 mcause, 0xF14 mhartid.
- A CSR is read-only when `addr[11:10] == 2'b11`.
- FSM states: IDLE, EXEC, T_EPC, T_CAUSE, T_STAT, T_VEC, M_STAT, M_EPC.
- `req_ready` is 1 only in IDLE. Acceptance is `req_valid & req_ready`; all `req_*` fields are latched at acceptance.
- Transitions from IDLE on acceptance:
  - ops 0-2 and reserved ops go to EXEC.
  - TRAP goes to T_EPC.
  - MRET goes to M_STAT.
- EXEC (CSR read-modify-write):
  - `csr_addr` = latched address; `old` = `csr_out`.
  - new value: CSRRW = operand; CSRRS = old | operand; CSRRC = old & ~operand.
  - A write occurs when op is CSRRW, or when `!rs1_zero`.
  - The access is illegal when the address is unmapped, when op is reserved, or when a write occurs to a read-only CSR.
  - `csr_write_en` = write occurs & !illegal.
  - Response: `rsp_valid`=1, `rsp_data`=old (0 if illegal), `rsp_illegal` as computed, `rsp_redirect`=0, `rsp_cause`=CAUSE_ILLEGAL if illegal, else 0.
  - Next state: IDLE.
- TRAP sequence, one CSR write per state:
  - T_EPC: write mepc = {pc[31:2], 2'b00}.
  - T_CAUSE: write mcause = cause.
  - T_STAT: write mstatus with MPIE(bit 7) = MIE(bit 3), MIE = 0, MPP(bits 12:11) = 2'b11; all other bits are kept from `mstatus`.
  - T_VEC: read mtvec; `rsp_valid`=1, `rsp_redirect`=1, `rsp_data` = `csr_out & ~32'h3`. Next state: IDLE.
- MRET sequence:
  - M_STAT: write mstatus with MIE = MPIE, MPIE = 1, MPP = 2'b11.
  - M_EPC: read mepc; `rsp_valid`=1, `rsp_redirect`=1, `rsp_data` = mepc. Next state: IDLE.
- In any state that neither writes nor reads, `csr_addr`=0, `csr_in`=0 and `csr_write_en`=0.

## Timing
- Reset (asynchronous, any state): FSM returns to IDLE. All outputs are 0 except `req_ready`, which is 1 once `rst_n` is high.
- Reset mid-sequence abandons the sequence. Writes already done stay in the CSR file; no `rsp_valid` is issued.
- Latency, for a request accepted at edge N:
  - CSR op: `rsp_valid` in cycle N+1.
  - TRAP: `rsp_valid` in cycle N+4.
  - MRET: `rsp_valid` in cycle N+2.
- The response has no backpressure. `rsp_*` outputs are valid only while `rsp_valid`=1 and are 0 otherwise.
- `req_ready` returns to 1 in the cycle after `rsp_valid`. Peak throughput is one CSR op per 2 cycles.
- The CSR read in EXEC/T_VEC/M_EPC is combinational through the file. The write lands at the closing edge of the same cycle.
- A request arriving while busy is ignored (`req_ready`=0). The requester must hold it stable.

## Test plan
- CSRRW mscratch: mscratch=0x11, operand 0xAA -> `rsp_data`=0x11 at N+1; mscratch reads back 0xAA.
- CSRRS/CSRRC on mie: mie=0x0F0, CSRRS operand 0x808 -> `rsp_data`=0x0F0, mie=0x8F8. CSRRC operand 0x0F0 -> mie=0x808. CSRRS with `rs1_zero` -> no `csr_write_en` pulse.
- mhartid: CSRRS with `rs1_zero` -> legal, returns hartid. CSRRW to 0xF14 -> `rsp_illegal`=1, `rsp_cause`=2, no write. Read of 0x7C0 -> illegal.
- TRAP: mtvec=0x1003, mstatus=0x8, pc=0x2002, cause=11 -> mepc=0x2000, mcause=11, mstatus=0x1880; `rsp_valid`/`rsp_redirect` at N+4 with `rsp_data`=0x1000.
- MRET after the TRAP above -> mstatus=0x1888, `rsp_data`=0x2000 at N+2.
- Reset: drop `rst_n` during T_CAUSE -> all outputs 0 immediately; mepc updated, mcause unchanged, no `rsp_valid`; `req_ready`=1 after release.
